conv_icb_arb: RTL and testbench

- Three-requester ICB arbiter for the conv accelerator.
- Shares the accelerator's single ICB master port between three engines: weight loader (req 0), input-row loader (req 1) and output writer (req 2).
- Grants commands round-robin and tracks outstanding transactions in an ID FIFO, so each response returns to the requester that issued it.
- Sits between the conv sequencing engines and the SoC ICB fabric.

---
 rtl/conv_icb_arb_if.sv | 48 ++++
 rtl/conv_icb_arb.sv | 174 +++++++++++++++++
 tb/tb_conv_icb_arb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_icb_arb_if.sv
// Bus bundle for the conv ICB arbiter: three requester command/response
// channels on one side, the single shared ICB master port on the other.
interface conv_icb_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int MW = DW / 8;

    // requester side, requester i in bit i / slice i
    logic [2:0]      req_cmd_valid;
    logic [2:0]      req_cmd_ready;
    logic [2:0]      req_cmd_read;
    logic [3*AW-1:0] req_cmd_addr;
    logic [3*DW-1:0] req_cmd_wdata;
    logic [3*MW-1:0] req_cmd_wmask;
    logic [2:0]      req_rsp_valid;
    logic [2:0]      req_rsp_ready;
    logic [DW-1:0]   req_rsp_rdata;

    // shared master port toward the fabric
    logic            m_cmd_valid;
    logic            m_cmd_ready;
    logic            m_cmd_read;
    logic [AW-1:0]   m_cmd_addr;
    logic [DW-1:0]   m_cmd_wdata;
    logic [MW-1:0]   m_cmd_wmask;
    logic            m_rsp_valid;
    logic            m_rsp_ready;
    logic [DW-1:0]   m_rsp_rdata;

    // arbiter view
    modport slave (
        input  req_cmd_valid, req_cmd_read, req_cmd_addr, req_cmd_wdata,
               req_cmd_wmask, req_rsp_ready, m_cmd_ready, m_rsp_valid,
               m_rsp_rdata,
        output req_cmd_ready, req_rsp_valid, req_rsp_rdata, m_cmd_valid,
               m_cmd_read, m_cmd_addr, m_cmd_wdata, m_cmd_wmask, m_rsp_ready
    );

    // environment view: engines plus fabric
    modport master (
        output req_cmd_valid, req_cmd_read, req_cmd_addr, req_cmd_wdata,
               req_cmd_wmask, req_rsp_ready, m_cmd_ready, m_rsp_valid,
               m_rsp_rdata,
        input  req_cmd_ready, req_rsp_valid, req_rsp_rdata, m_cmd_valid,
               m_cmd_read, m_cmd_addr, m_cmd_wdata, m_cmd_wmask, m_rsp_ready
    );
endinterface

// File: rtl/conv_icb_arb.sv
// Three-requester ICB arbiter for the conv accelerator. Round-robin command
// grant with a lock that freezes the granted payload under backpressure, and
// an ID FIFO that steers in-order responses back to the issuing requester.
module conv_icb_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int OUTS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    conv_icb_arb_if.slave                bus,
    output logic [$clog2(OUTS_DEPTH):0]  outstanding,
    output logic                         rsp_err
);
    localparam int MW = DW / 8;
    localparam int PW = $clog2(OUTS_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(OUTS_DEPTH);

    // grant state
    logic [1:0]    last_grant;
    logic [1:0]    locked_id;
    logic          lock;
    logic [1:0]    scan_gnt;
    logic [1:0]    gnt;
    logic [1:0]    c1, c2;
    logic          any_valid;
    logic [3:0]    cmd_valid4;

    // ID FIFO
    logic [1:0]    id_mem [OUTS_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          fifo_full, fifo_empty;
    logic [1:0]    head;
    logic [3:0]    rsp_ready4;

    logic          cmd_hs, rsp_hs;
    logic [2:0]    cmd_ready_v, rsp_valid_v;

    // unpacked per-requester payloads
    logic [AW-1:0] addr_a  [3];
    logic [DW-1:0] wdata_a [3];
    logic [MW-1:0] wmask_a [3];

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    for (genvar i = 0; i < 3; i++) begin : g_req
        assign addr_a[i]  = bus.req_cmd_addr[i*AW +: AW];
        assign wdata_a[i] = bus.req_cmd_wdata[i*DW +: DW];
        assign wmask_a[i] = bus.req_cmd_wmask[i*MW +: MW];
    end

    // Padded to 4 bits so a 2-bit id can index them without range issues.
    assign cmd_valid4 = {1'b0, bus.req_cmd_valid};
    assign rsp_ready4 = {1'b0, bus.req_rsp_ready};
    assign any_valid  = |bus.req_cmd_valid;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign head       = id_mem[rd_ptr];

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        c1 = inc3(last_grant);
        c2 = inc3(c1);
        if (cmd_valid4[c1])              scan_gnt = c1;
        else if (cmd_valid4[c2])         scan_gnt = c2;
        else if (cmd_valid4[last_grant]) scan_gnt = last_grant;
        else                             scan_gnt = c1;
    end

    // A backpressured grant stays pinned until its handshake completes.
    assign gnt = lock ? locked_id : scan_gnt;

    // Zero-latency command path: mux the granted requester onto the master.
    always_comb begin
        bus.m_cmd_valid = cmd_valid4[gnt] & any_valid & ~fifo_full;
        bus.m_cmd_read  = 1'b0;
        bus.m_cmd_addr  = '0;
        bus.m_cmd_wdata = '0;
        bus.m_cmd_wmask = '0;
        case (gnt)
            2'd0: begin
                bus.m_cmd_read  = bus.req_cmd_read[0];
                bus.m_cmd_addr  = addr_a[0];
                bus.m_cmd_wdata = wdata_a[0];
                bus.m_cmd_wmask = wmask_a[0];
            end
            2'd1: begin
                bus.m_cmd_read  = bus.req_cmd_read[1];
                bus.m_cmd_addr  = addr_a[1];
                bus.m_cmd_wdata = wdata_a[1];
                bus.m_cmd_wmask = wmask_a[1];
            end
            2'd2: begin
                bus.m_cmd_read  = bus.req_cmd_read[2];
                bus.m_cmd_addr  = addr_a[2];
                bus.m_cmd_wdata = wdata_a[2];
                bus.m_cmd_wmask = wmask_a[2];
            end
            default: ;
        endcase
    end

    // Only the granted requester sees ready; only the FIFO head sees rsp valid.
    always_comb begin
        cmd_ready_v = '0;
        rsp_valid_v = '0;
        for (int i = 0; i < 3; i++) begin
            cmd_ready_v[i] = (gnt == 2'(i)) & bus.m_cmd_ready & ~fifo_full;
            rsp_valid_v[i] = (head == 2'(i)) & bus.m_rsp_valid & ~fifo_empty;
        end
    end

    assign bus.req_cmd_ready = cmd_ready_v;
    assign bus.req_rsp_valid = rsp_valid_v;
    assign bus.req_rsp_rdata = bus.m_rsp_rdata;
    assign bus.m_rsp_ready   = rsp_ready4[head] & ~fifo_empty;

    assign cmd_hs = bus.m_cmd_valid & bus.m_cmd_ready;
    assign rsp_hs = bus.m_rsp_valid & bus.m_rsp_ready;

    // Round-robin pointer advances to whoever just completed a command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_grant <= 2'd2;
        else if (cmd_hs) last_grant <= gnt;
    end

    // Lock on a stalled command so its payload cannot switch requesters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock      <= 1'b0;
            locked_id <= 2'd0;
        end else if (bus.m_cmd_valid & ~bus.m_cmd_ready) begin
            lock      <= 1'b1;
            locked_id <= gnt;
        end else if (cmd_hs) begin
            lock      <= 1'b0;
        end
    end

    // ID storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (cmd_hs) id_mem[wr_ptr] <= gnt;
    end

    // FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (cmd_hs) wr_ptr <= wr_ptr + 1'b1;
            if (rsp_hs) rd_ptr <= rd_ptr + 1'b1;
            case ({cmd_hs, rsp_hs})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             rsp_err <= 1'b0;
        else if (bus.m_rsp_valid & fifo_empty)  rsp_err <= 1'b1;
    end

    assign outstanding = count;

endmodule

// File: tb/tb_conv_icb_arb.sv
// Randomized and directed bench for conv_icb_arb against a transaction-level
// model: a queue of issuer ids, a round-robin pointer and a pending-grant hold.
module tb_conv_icb_arb;
    localparam int AW = 32, DW = 32, MW = DW / 8, DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] outstanding;
    logic       rsp_err;

    conv_icb_arb_if #(.AW(AW), .DW(DW)) bus();

    conv_icb_arb #(.AW(AW), .DW(DW), .OUTS_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // stimulus
    logic [2:0]    vld = '0, rd = '0, rrdy = '0;
    logic [AW-1:0] a  [3];
    logic [DW-1:0] wd [3];
    logic [MW-1:0] wm [3];
    logic          mrdy = 1'b0, mrv = 1'b0;
    logic [DW-1:0] mrd = '0;

    // reference model
    int       lg = 2;
    bit       lk = 1'b0;
    int       lid = 0;
    int       q[$];
    bit       err = 1'b0;
    int       waitc[3] = '{0, 0, 0};
    bit [2:0] hs_vec = '0;

    // observations at mid-cycle
    logic          obs_mvalid, obs_mrr;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata, obs_rdata;
    logic [MW-1:0] obs_wmask;
    logic [2:0]    obs_rv;

    task automatic apply();
        bus.req_cmd_valid = vld;
        bus.req_cmd_read  = rd;
        for (int i = 0; i < 3; i++) begin
            bus.req_cmd_addr[i*AW +: AW]  = a[i];
            bus.req_cmd_wdata[i*DW +: DW] = wd[i];
            bus.req_cmd_wmask[i*MW +: MW] = wm[i];
        end
        bus.req_rsp_ready = rrdy;
        bus.m_cmd_ready   = mrdy;
        bus.m_rsp_valid   = mrv;
        bus.m_rsp_rdata   = mrd;
    endtask

    task automatic model_reset();
        lg = 2; lk = 1'b0; lid = 0; q.delete(); err = 1'b0;
        for (int i = 0; i < 3; i++) waitc[i] = 0;
        hs_vec = '0;
    endtask

    // One clock: called at posedge+1, checks at mid-cycle, returns at next posedge+1.
    task automatic step();
        int g, hd;
        bit full, emv, hs, pop, empty;
        logic [2:0] er, erv;
        apply();
        #4;
        obs_mvalid = bus.m_cmd_valid;  obs_addr  = bus.m_cmd_addr;
        obs_wdata  = bus.m_cmd_wdata;  obs_wmask = bus.m_cmd_wmask;
        obs_rv     = bus.req_rsp_valid; obs_mrr  = bus.m_rsp_ready;
        obs_rdata  = bus.req_rsp_rdata;

        full  = (q.size() >= DEPTH);
        empty = (q.size() == 0);
        g = -1;
        if (lk) g = lid;
        else for (int k = 1; k <= 3; k++) if (g < 0 && vld[(lg + k) % 3]) g = (lg + k) % 3;
        emv = (g >= 0) && vld[g] && !full;

        chk("m_cmd_valid", 64'(obs_mvalid), 64'(emv));
        if (g >= 0) begin
            er = '0;
            if (mrdy && !full) er[g] = 1'b1;
            chk("req_cmd_ready", 64'(bus.req_cmd_ready), 64'(er));
        end
        if (emv) begin
            chk("m_cmd_read",  64'(bus.m_cmd_read), 64'(rd[g]));
            chk("m_cmd_addr",  64'(obs_addr),  64'(a[g]));
            chk("m_cmd_wdata", 64'(obs_wdata), 64'(wd[g]));
            chk("m_cmd_wmask", 64'(obs_wmask), 64'(wm[g]));
        end
        hd  = empty ? 0 : q[0];
        erv = (!empty && mrv) ? (3'b001 << hd) : 3'b000;
        chk("req_rsp_valid", 64'(obs_rv),  64'(erv));
        chk("m_rsp_ready",   64'(obs_mrr), 64'(!empty && rrdy[hd]));
        if (mrv) chk("req_rsp_rdata", 64'(obs_rdata), 64'(mrd));
        chk("outstanding", 64'(outstanding), 64'(q.size()));
        chk("rsp_err",     64'(rsp_err),     64'(err));

        hs  = emv && mrdy;
        pop = !empty && mrv && rrdy[hd];
        for (int i = 0; i < 3; i++) begin
            if (hs && g == i) begin
                chk("starvation", 64'(waitc[i] <= 2), 64'(1));
                waitc[i] = 0;
            end else if (!vld[i]) waitc[i] = 0;
            else if (hs) waitc[i]++;
        end
        if (emv && !mrdy) begin lk = 1'b1; lid = g; end
        else if (hs) lk = 1'b0;
        hs_vec = hs ? (3'b001 << g) : 3'b000;
        if (mrv && empty) err = 1'b1;
        if (pop) void'(q.pop_front());
        if (hs) begin q.push_back(g); lg = g; end

        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        vld = '0; mrdy = 1'b1; mrv = 1'b0;
        for (int k = 0; k < 30 && q.size() > 0; k++) begin
            mrv = 1'b1; rrdy = '1; mrd = $urandom;
            step();
        end
        mrv = 1'b0; rrdy = '0;
        chk("drain_done", 64'(outstanding), 64'(0));
    endtask

    int ord[4] = '{1, 0, 2, 1};

    initial begin
        for (int i = 0; i < 3; i++) begin a[i] = '0; wd[i] = '0; wm[i] = '0; end
        apply();
        #3;
        chk("rst_m_cmd_valid",   64'(bus.m_cmd_valid),   64'(0));
        chk("rst_m_rsp_ready",   64'(bus.m_rsp_ready),   64'(0));
        chk("rst_req_cmd_ready", 64'(bus.req_cmd_ready), 64'(0));
        chk("rst_req_rsp_valid", 64'(bus.req_rsp_valid), 64'(0));
        chk("rst_outstanding",   64'(outstanding),       64'(0));
        chk("rst_rsp_err",       64'(rsp_err),           64'(0));
        @(posedge clk); #1; rst_n = 1'b1;
        model_reset();

        // all three valid, instant responses: strict 0,1,2 rotation
        for (int i = 0; i < 3; i++) begin a[i] = 32'h1000_0000 + i; wd[i] = $urandom; wm[i] = 4'hF; end
        vld = 3'b111; rd = 3'b111; mrdy = 1'b1; rrdy = 3'b111;
        for (int k = 0; k < 6; k++) begin
            mrv = (q.size() > 0); mrd = $urandom;
            step();
            chk("rr_order", 64'(obs_addr), 64'(32'h1000_0000 + k % 3));
        end
        drain();

        // single read from requester 1
        vld = 3'b010; rd[1] = 1'b1; a[1] = 32'h4000_0000; mrdy = 1'b1; mrv = 1'b0;
        step();
        chk("t1_same_cycle", 64'(obs_mvalid), 64'(1));
        chk("t1_outs1", 64'(outstanding), 64'(1));
        vld = '0; mrv = 1'b1; mrd = 32'hA5A5_0001; rrdy = 3'b111;
        step();
        chk("t1_rsp_valid", 64'(obs_rv), 64'(3'b010));
        chk("t1_rdata", 64'(obs_rdata), 64'(32'hA5A5_0001));
        mrv = 1'b0;
        step();
        chk("t1_outs0", 64'(outstanding), 64'(0));

        // backpressure holds requester 2's write despite requester 0 arriving
        vld = 3'b100; rd[2] = 1'b0; a[2] = 32'h6000_0000; wd[2] = 32'h0102_0304; wm[2] = 4'hF;
        rd[0] = 1'b1; a[0] = 32'h7000_0000;
        mrdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) vld = 3'b101;
            if (k == 3) mrdy = 1'b1;
            step();
            chk("bp_hold_addr", 64'(obs_addr), 64'(32'h6000_0000));
        end
        chk("bp_wdata", 64'(obs_wdata), 64'(32'h0102_0304));
        vld = 3'b001;
        step();
        chk("bp_then_req0", 64'(obs_addr), 64'(32'h7000_0000));
        drain();

        // fill the ID FIFO, then free one slot
        vld = 3'b001; rd[0] = 1'b1; mrdy = 1'b1; mrv = 1'b0;
        for (int k = 0; k < 4; k++) begin a[0] = 32'h8000_0000 + k * 4; step(); end
        a[0] = 32'h8000_0010;
        step();
        chk("full_block", 64'(obs_mvalid), 64'(0));
        chk("full_outs",  64'(outstanding), 64'(4));
        mrv = 1'b1; rrdy = 3'b001; mrd = 32'hF00D_0000;
        step();
        chk("full_pop_same", 64'(obs_mvalid), 64'(0));
        chk("full_rsp_to0",  64'(obs_rv), 64'(3'b001));
        mrv = 1'b0;
        step();
        chk("full_issue_next", 64'(obs_mvalid), 64'(1));
        drain();

        // interleaved issue, in-order routing, stall on a not-ready requester
        rd = 3'b111; mrdy = 1'b1; mrv = 1'b0;
        for (int k = 0; k < 4; k++) begin vld = 3'b001 << ord[k]; step(); end
        vld = '0; mrv = 1'b1; rrdy = 3'b101; mrd = 32'hD000_0000;
        step();
        chk("il_stall_ready", 64'(obs_mrr), 64'(0));
        chk("il_stall_valid", 64'(obs_rv),  64'(3'b010));
        rrdy = 3'b111;
        for (int k = 0; k < 4; k++) begin
            mrd = 32'hD000_0000 + k;
            step();
            chk("il_route", 64'(obs_rv), 64'(3'b001 << ord[k]));
            chk("il_rdata", 64'(obs_rdata), 64'(32'hD000_0000 + k));
        end
        mrv = 1'b0;
        drain();

        // randomized traffic honouring valid-hold on both sides
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(vld[i] && !hs_vec[i])) begin
                    vld[i] = ($urandom_range(0, 99) < 55);
                    rd[i]  = $urandom_range(0, 1) == 1;
                    a[i]   = $urandom;
                    wd[i]  = $urandom;
                    wm[i]  = 4'($urandom);
                end
            end
            mrdy = ($urandom_range(0, 9) < 7);
            mrv  = (q.size() > 0) && ($urandom_range(0, 9) < 6);
            mrd  = $urandom;
            rrdy = 3'($urandom);
            step();
        end
        for (int k = 0; k < 30 && vld != 3'b000; k++) begin
            vld  = vld & ~hs_vec;
            mrdy = 1'b1; mrv = (q.size() > 0); rrdy = 3'b111; mrd = $urandom;
            step();
        end
        drain();

        // response with nothing outstanding
        vld = '0; mrv = 1'b1; mrd = 32'hBAD0_0000;
        step();
        chk("err_set", 64'(rsp_err), 64'(1));
        mrv = 1'b0;
        step();
        step();
        chk("err_sticky", 64'(rsp_err), 64'(1));

        // reset with two reads in flight
        vld = 3'b001; rd[0] = 1'b1; mrdy = 1'b1;
        step(); step();
        chk("pre_rst_outs", 64'(outstanding), 64'(2));
        vld = '0; mrdy = 1'b0; apply();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs",   64'(outstanding),     64'(0));
        chk("mid_rst_err",    64'(rsp_err),         64'(0));
        chk("mid_rst_mvalid", 64'(bus.m_cmd_valid), 64'(0));
        model_reset();
        @(posedge clk); #1; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) a[i] = 32'h2000_0000 + i;
        vld = 3'b111; mrdy = 1'b1;
        step();
        chk("post_rst_gnt0", 64'(obs_addr), 64'(32'h2000_0000));
        vld = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
